// File: rtl/debug_pkg.sv
// debug_pkg: shared sizing, word-index constants and FSM encoding for the debug dump sequencer.
// DEBUG_DUMP_CHECKSUM_EN adds the trailing XOR checksum states.
package debug_pkg;
    localparam int NB         = 32;
    localparam int DATA_BITS  = 8;
    localparam int N_REGS     = 32;
    localparam int BPW        = NB / DATA_BITS;
    localparam int W_PC       = 0;
    localparam int W_REG_BASE = 1;
    localparam int W_ALU      = N_REGS + 1;
    localparam int WW         = $clog2(N_REGS + 2);
    localparam int BW         = $clog2(BPW + 1);
    typedef enum logic [2:0] {
        IDLE, LOAD, SEND, WAIT, DONE
`ifdef DEBUG_DUMP_CHECKSUM_EN
        , CSUM_SEND, CSUM_WAIT
`endif
    } state_t;
endpackage

// File: rtl/debug_dump_sequencer_if.sv
// debug_dump_sequencer_if: start/done, MIPS read port and UART handshake bundle.
interface debug_dump_sequencer_if;
    import debug_pkg::*;
    logic                 i_start;
    logic [NB-1:0]        i_mips_pc;
    logic [NB-1:0]        i_mips_register;
    logic [NB-1:0]        i_mips_alu_result;
    logic                 i_uart_tx_done;
    logic                 o_uart_tx_ready;
    logic [DATA_BITS-1:0] o_uart_tx_data;
    logic [NB-1:0]        o_mips_register_number;
    logic                 o_busy;
    logic                 o_done;
    modport master (
        output i_start, i_mips_pc, i_mips_register, i_mips_alu_result, i_uart_tx_done,
        input  o_uart_tx_ready, o_uart_tx_data, o_mips_register_number, o_busy, o_done
    );
    modport slave (
        input  i_start, i_mips_pc, i_mips_register, i_mips_alu_result, i_uart_tx_done,
        output o_uart_tx_ready, o_uart_tx_data, o_mips_register_number, o_busy, o_done
    );
endinterface

// File: rtl/word_serializer.sv
// word_serializer: snapshots one NB-bit word and presents it DATA_BITS at a time, MSB first.
module word_serializer
    import debug_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 load,
    input  logic                 shift,
    input  logic [NB-1:0]        word,
    output logic [DATA_BITS-1:0] top_byte,
    output logic                 last_byte
);
    logic [NB-1:0] sr;
    logic [BW-1:0] cnt;
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= word;
            cnt <= '0;
        end else if (shift) begin
            sr  <= sr << DATA_BITS;
            cnt <= cnt + 1'b1;
        end
    end
    assign top_byte  = sr[NB-1 -: DATA_BITS];
    assign last_byte = cnt == BW'(BPW - 1);
endmodule

// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer: streams PC, register file and ALU result to the UART transmitter byte by byte.
// DEBUG_DUMP_CHECKSUM_EN appends one XOR checksum byte after the data.
module debug_dump_sequencer
    import debug_pkg::*;
(
    input logic                   i_clk,
    input logic                   i_reset,
    debug_dump_sequencer_if.slave bus
);
    state_t               state, next;
    logic [WW-1:0]        w;
    logic                 load, shift, w_clr, w_inc, last_byte, in_reg;
    logic [DATA_BITS-1:0] top_byte;
    logic [NB-1:0]        word_sel;
    assign in_reg   = w >= WW'(W_REG_BASE) && w <= WW'(N_REGS);
    assign word_sel = w == WW'(W_PC)  ? bus.i_mips_pc :
                      w == WW'(W_ALU) ? bus.i_mips_alu_result : bus.i_mips_register;
    word_serializer u_ser (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .load      (load),
        .shift     (shift),
        .word      (word_sel),
        .top_byte  (top_byte),
        .last_byte (last_byte)
    );
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= IDLE;
        else          state <= next;
    end
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)   w <= '0;
        else if (w_clr) w <= '0;
        else if (w_inc) w <= w + 1'b1;
    end
    always_comb begin
        next  = state;
        load  = 1'b0;
        shift = 1'b0;
        w_clr = 1'b0;
        w_inc = 1'b0;
        case (state)
            IDLE: if (bus.i_start) begin
                next  = LOAD;
                w_clr = 1'b1;
            end
            LOAD: begin
                next = SEND;
                load = 1'b1;
            end
            SEND: next = WAIT;
            WAIT: if (bus.i_uart_tx_done) begin
                if (!last_byte) begin
                    shift = 1'b1;
                    next  = SEND;
                end else if (w != WW'(W_ALU)) begin
                    w_inc = 1'b1;
                    next  = LOAD;
                end else begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                    next = CSUM_SEND;
`else
                    next = DONE;
`endif
                end
            end
`ifdef DEBUG_DUMP_CHECKSUM_EN
            CSUM_SEND: next = CSUM_WAIT;
            CSUM_WAIT: if (bus.i_uart_tx_done) next = DONE;
`endif
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end
    logic [DATA_BITS-1:0] data_byte;
    assign data_byte = (state == SEND || state == WAIT) ? top_byte : '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [DATA_BITS-1:0] acc;
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)            acc <= '0;
        else if (w_clr)          acc <= '0;
        else if (state == SEND)  acc <= acc ^ top_byte;
    end
    assign bus.o_uart_tx_ready = state == SEND || state == CSUM_SEND;
    assign bus.o_uart_tx_data  = (state == CSUM_SEND || state == CSUM_WAIT) ? acc : data_byte;
`else
    assign bus.o_uart_tx_ready = state == SEND;
    assign bus.o_uart_tx_data  = data_byte;
`endif
    assign bus.o_mips_register_number = in_reg ? NB'(w - WW'(W_REG_BASE)) : '0;
    assign bus.o_busy = state != IDLE;
    assign bus.o_done = state == DONE;
endmodule

// File: tb/tb_debug_dump_sequencer.sv
// tb_debug_dump_sequencer: randomized and directed dumps checked against a byte-list model.
module tb_debug_dump_sequencer;
    import debug_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    debug_dump_sequencer_if bus();
    debug_dump_sequencer dut (.i_clk(clk), .i_reset(rst_n), .bus(bus));
    logic [NB-1:0] regs [N_REGS];
    assign bus.i_mips_register = regs[int'(bus.o_mips_register_number) % N_REGS];
    int tests = 0;
    int fails = 0;
    logic [DATA_BITS-1:0] got[$];
    logic [DATA_BITS-1:0] exp_q[$];
    int done_cnt;

    task automatic build_expected(input logic [NB-1:0] pc, input logic [NB-1:0] alu);
        logic [NB-1:0]        words[$];
        logic [DATA_BITS-1:0] b;
        logic [DATA_BITS-1:0] x = '0;
        exp_q.delete();
        words.push_back(pc);
        for (int i = 0; i < N_REGS; i++) words.push_back(regs[i]);
        words.push_back(alu);
        foreach (words[i])
            for (int k = 0; k < BPW; k++) begin
                b = DATA_BITS'(words[i] >> (NB - DATA_BITS * (k + 1)));
                exp_q.push_back(b);
                x ^= b;
            end
`ifdef DEBUG_DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic run_dump(input int dly, input bit spur, input bit chg_pc, input bit spam, input int abort_after);
        bit pending = 0;
        bit seen_done = 0;
        bit finished = 0;
        int cd = 0;
        int tail = 20;
        int idx, widx;
        logic [DATA_BITS-1:0] cur = '0;
        logic [NB-1:0] prev_rn = '0;
        logic [NB-1:0] exp_rn;
        got.delete();
        done_cnt = 0;
        @(negedge clk);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        tests++;
        if (bus.o_busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_after_start: got %b want 1", bus.o_busy);
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            bus.i_uart_tx_done = 1'b0;
            bus.i_start = 1'b0;
            if (bus.o_uart_tx_ready) begin
                tests++;
                if (pending) begin
                    fails++;
                    $display("FAIL double_ready: byte %0d issued before previous done", got.size());
                end
                cur = bus.o_uart_tx_data;
                got.push_back(cur);
                pending = 1;
                cd = dly > 0 ? dly : int'($urandom_range(1, 12));
                idx = got.size() - 1;
                widx = idx / BPW;
                exp_rn = (widx >= 1 && widx <= N_REGS) ? NB'(widx - 1) : '0;
                tests++;
                if (bus.o_mips_register_number !== exp_rn) begin
                    fails++;
                    $display("FAIL reg_number byte %0d: got %0d want %0d", idx, bus.o_mips_register_number, exp_rn);
                end
                if (idx % BPW == 0) begin
                    tests++;
                    if (prev_rn !== exp_rn) begin
                        fails++;
                        $display("FAIL reg_number_load word %0d: got %0d want %0d", widx, prev_rn, exp_rn);
                    end
                end
                if (spur) bus.i_uart_tx_done = 1'b1;
                if (chg_pc && idx == 1) bus.i_mips_pc = '1;
                if (abort_after > 0 && got.size() == abort_after) return;
            end else if (pending) begin
                tests++;
                if (bus.o_uart_tx_data !== cur) begin
                    fails++;
                    $display("FAIL data_hold byte %0d: got %h want %h", got.size() - 1, bus.o_uart_tx_data, cur);
                end
                cd--;
                if (cd == 0) begin
                    bus.i_uart_tx_done = 1'b1;
                    pending = 0;
                end
            end
            if (bus.o_done) begin
                done_cnt++;
                seen_done = 1;
                if (spam) bus.i_start = 1'b1;
            end else if (spam && bus.o_busy && $urandom_range(0, 3) == 0) bus.i_start = 1'b1;
            prev_rn = bus.o_mips_register_number;
            if (seen_done) begin
                if (tail == 0) begin
                    finished = 1;
                    break;
                end
                tail--;
            end
            @(negedge clk);
        end
        bus.i_start = 1'b0;
        bus.i_uart_tx_done = 1'b0;
        tests++;
        if (!finished) begin
            fails++;
            $display("FAIL dump_timeout: got %0d bytes want %0d", got.size(), exp_q.size());
        end
        tests++;
        if (got.size() != exp_q.size()) begin
            fails++;
            $display("FAIL byte_count: got %0d want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL byte %0d: got %h want %h", i, got[i], exp_q[i]);
            end
        end
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL done_pulses: got %0d want 1", done_cnt);
        end
        tests++;
        if (bus.o_busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_after_done: got %b want 0", bus.o_busy);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        tests++;
        if ({bus.o_busy, bus.o_done, bus.o_uart_tx_ready} !== 3'b000 || bus.o_uart_tx_data !== '0 ||
            bus.o_mips_register_number !== '0) begin
            fails++;
            $display("FAIL %s: busy/done/ready=%b%b%b data=%h regnum=%0d want all 0", tag,
                     bus.o_busy, bus.o_done, bus.o_uart_tx_ready, bus.o_uart_tx_data, bus.o_mips_register_number);
        end
    endtask

    task automatic fill_fixed();
        bus.i_mips_pc = 32'h0040_0010;
        bus.i_mips_alu_result = 32'hDEAD_BEEF;
        for (int k = 0; k < N_REGS; k++) regs[k] = 32'h1111_0000 + k;
    endtask

    task automatic fill_random();
        bus.i_mips_pc = $urandom;
        bus.i_mips_alu_result = $urandom;
        for (int k = 0; k < N_REGS; k++) regs[k] = $urandom;
    endtask

    task automatic test_reset();
        @(negedge clk);
        check_idle_outputs("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_fixed_pattern();
        logic [DATA_BITS-1:0] head[8];
        logic [DATA_BITS-1:0] tailb[4];
        head  = '{8'h00, 8'h40, 8'h00, 8'h10, 8'h11, 8'h11, 8'h00, 8'h00};
        tailb = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        fill_fixed();
        build_expected(bus.i_mips_pc, bus.i_mips_alu_result);
        run_dump(10, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (got.size() <= i || got[i] !== head[i]) begin
                fails++;
                $display("FAIL fixed_head %0d: got %h want %h", i, got.size() > i ? got[i] : 8'hxx, head[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (got.size() < (N_REGS + 2) * BPW || got[(N_REGS + 1) * BPW + i] !== tailb[i]) begin
                fails++;
                $display("FAIL fixed_alu %0d: want %h", i, tailb[i]);
            end
        end
    endtask

    task automatic test_spurious_done();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.i_uart_tx_done = 1'b1;
            @(negedge clk);
            bus.i_uart_tx_done = 1'b0;
            check_idle_outputs("spurious_idle");
        end
        fill_random();
        build_expected(bus.i_mips_pc, bus.i_mips_alu_result);
        run_dump(0, 1, 0, 0, 0);
    endtask

    task automatic test_start_ignored();
        fill_random();
        build_expected(bus.i_mips_pc, bus.i_mips_alu_result);
        run_dump(0, 0, 0, 1, 0);
        repeat (5) @(negedge clk);
        check_idle_outputs("no_queued_start");
    endtask

    task automatic test_reset_mid();
        fill_fixed();
        build_expected(bus.i_mips_pc, bus.i_mips_alu_result);
        run_dump(10, 0, 0, 0, 5);
        @(negedge clk);
        bus.i_uart_tx_done = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("async_reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        run_dump(10, 0, 0, 0, 0);
        tests++;
        if (got.size() == 0 || got[0] !== bus.i_mips_pc[NB-1 -: DATA_BITS]) begin
            fails++;
            $display("FAIL restart_first_byte: got %h want %h", got.size() > 0 ? got[0] : 8'hxx,
                     bus.i_mips_pc[NB-1 -: DATA_BITS]);
        end
    endtask

    task automatic test_random();
        fill_random();
        build_expected(bus.i_mips_pc, bus.i_mips_alu_result);
        run_dump(0, $urandom_range(0, 1) == 1, 0, $urandom_range(0, 1) == 1, 0);
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_uart_tx_done = 1'b0;
        bus.i_mips_pc = '0;
        bus.i_mips_alu_result = '0;
        for (int k = 0; k < N_REGS; k++) regs[k] = '0;
        test_reset();
        test_fixed_pattern();
        test_spurious_done();
        test_start_ignored();
        test_reset_mid();
        repeat (2) test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
